// File: rtl/avmm_bidir_pio_v2_if.sv
// Avalon-MM slave bus bundle for avmm_bidir_pio_v2.
//   address    word address (3 bits)
//   chipselect slave select
//   write_n    write strobe, active-low
//   writedata  write data (32 bits)
//   readdata   registered read data (32 bits)
// The master modport is the fabric side; the slave modport is the PIO side.
interface avmm_bidir_pio_v2_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/avmm_bidir_pio_v2.sv
// Avalon-MM bidirectional PIO.
// Controls WIDTH bidirectional pins with per-bit direction, atomic set/clear of output bits,
// optional open-drain drive, an input synchroniser and maskable edge capture with a level irq.
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset
//   bus        Avalon-MM slave bundle (address, chipselect, write_n, writedata, readdata)
//   bidir_port WIDTH bidirectional pins
//   irq        level interrupt, active-high, registered
// Register map (read / write):
//   0 DATA   sync_in  / data_out <= wd
//   1 DIR    dir      / dir <= wd (1 = output)
//   2 MASK   irq_mask / irq_mask <= wd
//   3 EDGE   edge_cap / write-1-to-clear
//   4 OUTSET data_out / data_out |= wd
//   5 OUTCLR data_out / data_out &= ~wd
//   6,7      0        / ignored
module avmm_bidir_pio_v2 #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned OPEN_DRAIN  = 0,
    parameter bit [31:0]   RESET_DIR   = 32'd0,
    parameter bit [31:0]   RESET_OUT   = 32'd0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    avmm_bidir_pio_v2_if.slave        bus,
    inout  wire  [WIDTH-1:0]          bidir_port,
    output logic                      irq
);

    // Warm-up saturates once the whole chain and the prev register hold real pin samples.
    localparam logic [2:0] WarmMax = 3'(SYNC_STAGES + 1);

    localparam logic [WIDTH-1:0] DirRst = {WIDTH{RESET_DIR[0]}};
    localparam logic [WIDTH-1:0] OutRst = {WIDTH{RESET_OUT[0]}};

    logic [WIDTH-1:0]                  data_out_q, data_out_d;
    logic [WIDTH-1:0]                  dir_q, dir_d;
    logic [WIDTH-1:0]                  mask_q, mask_d;
    logic [WIDTH-1:0]                  cap_q, cap_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [2:0]                        warm_q, warm_d;
    logic [31:0]                       readdata_q, readdata_d;
    logic                              irq_q, irq_d;

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] detect;
    logic [WIDTH-1:0] clr;
    logic             warm_done;
    logic             unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;
    assign sync_in   = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_q == WarmMax);

    // Pin drivers
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        if (OPEN_DRAIN != 0) begin : g_od
            assign bidir_port[i] = (dir_q[i] & ~data_out_q[i]) ? 1'b0 : 1'bz;
        end else begin : g_pp
            assign bidir_port[i] = dir_q[i] ? data_out_q[i] : 1'bz;
        end
    end

    always_comb begin
        detect = '0;
        case (EDGE_TYPE)
            0:       detect = sync_in & ~prev_q;
            1:       detect = ~sync_in & prev_q;
            default: detect = sync_in ^ prev_q;
        endcase
    end

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        clr        = '0;
        readdata_d = '0;

        if (wr) begin
            case (bus.address)
                3'd0:    data_out_d = wd;
                3'd1:    dir_d      = wd;
                3'd2:    mask_d     = wd;
                3'd3:    clr        = wd;
                3'd4:    data_out_d = data_out_q | wd;
                3'd5:    data_out_d = data_out_q & ~wd;
                default: ;
            endcase
        end

        // Read mux is sampled every cycle regardless of chipselect.
        case (bus.address)
            3'd0:      readdata_d[WIDTH-1:0] = sync_in;
            3'd1:      readdata_d[WIDTH-1:0] = dir_q;
            3'd2:      readdata_d[WIDTH-1:0] = mask_q;
            3'd3:      readdata_d[WIDTH-1:0] = cap_q;
            3'd4, 3'd5: readdata_d[WIDTH-1:0] = data_out_q;
            default:   readdata_d = '0;
        endcase

        // A fresh edge beats a same-cycle clear.
        cap_d  = (warm_done ? detect : '0) | (cap_q & ~clr);
        irq_d  = |(cap_q & mask_q);
        warm_d = warm_done ? warm_q : warm_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out_q <= OutRst;
            dir_q      <= DirRst;
            mask_q     <= '0;
            cap_q      <= '0;
            sync_q     <= '0;
            prev_q     <= '0;
            warm_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bidir_port};
            prev_q     <= sync_in;
            warm_q     <= warm_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_avmm_bidir_pio_v2.sv
// Bench for avmm_bidir_pio_v2: two instances sharing one bus stimulus.
//   dut 0: push-pull, rising-edge capture, resets to 0, pins pulled down.
//   dut 1: open-drain, any-edge capture, data_out resets to all-ones, pins pulled up.
// A pin-history model predicts readdata, irq and pin levels every cycle; directed checks
// pin the model with hand-computed values.
module tb_avmm_bidir_pio_v2;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] addr = 3'd0;
    logic       cs = 1'b0;
    logic       wn = 1'b1;
    logic [31:0] wd = 32'd0;
    logic [7:0] ext_oe = 8'h00;
    logic [7:0] ext_val = 8'h00;
    logic [7:0] ext_en0, ext_en1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    avmm_bidir_pio_v2_if bus0 ();
    avmm_bidir_pio_v2_if bus1 ();

    assign bus0.address = addr;  assign bus1.address = addr;
    assign bus0.chipselect = cs; assign bus1.chipselect = cs;
    assign bus0.write_n = wn;    assign bus1.write_n = wn;
    assign bus0.writedata = wd;  assign bus1.writedata = wd;

    wire [7:0] pins0, pins1;
    logic irq0, irq1;

    // Model state, index 0/1 per dut
    logic [7:0]  m_do   [2];
    logic [7:0]  m_dir  [2];
    logic [7:0]  m_mask [2];
    logic [7:0]  m_cap  [2];
    logic [31:0] m_rd   [2];
    logic        m_irq  [2];
    int          m_wu   [2];
    logic [7:0]  hist   [2][S+1];  // hist[d][0] = most recent pin sample

    // External drivers only where the dut is not driving
    assign ext_en0 = ext_oe & ~m_dir[0];
    assign ext_en1 = ext_oe & ~(m_dir[1] & ~m_do[1]);

    for (genvar i = 0; i < 8; i++) begin : g_ext
        assign pins0[i] = ext_en0[i] ? ext_val[i] : 1'bz;
        assign pins1[i] = ext_en1[i] ? ext_val[i] : 1'bz;
        pulldown pd (pins0[i]);
        pullup   pu (pins1[i]);
    end

    avmm_bidir_pio_v2 #(
        .WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(0), .OPEN_DRAIN(0),
        .RESET_DIR(32'd0), .RESET_OUT(32'd0)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .bidir_port(pins0), .irq(irq0)
    );

    avmm_bidir_pio_v2 #(
        .WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(2), .OPEN_DRAIN(1),
        .RESET_DIR(32'd0), .RESET_OUT(32'd1)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .bidir_port(pins1), .irq(irq1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Pin level seen on the wire, from the electrical rules of each dut
    function automatic logic [7:0] exp_pin(input int d);
        logic [7:0] p;
        for (int b = 0; b < 8; b++) begin
            if (d == 0) begin
                if (m_dir[0][b])     p[b] = m_do[0][b];
                else if (ext_oe[b])  p[b] = ext_val[b];
                else                 p[b] = 1'b0;
            end else begin
                if (m_dir[1][b] && !m_do[1][b]) p[b] = 1'b0;
                else if (ext_oe[b])             p[b] = ext_val[b];
                else                            p[b] = 1'b1;
            end
        end
        return p;
    endfunction

    always @(posedge clk) begin
        logic [7:0] pin [2];
        logic [7:0] sync_in, prev, det, clr;
        pin[0] = exp_pin(0);
        pin[1] = exp_pin(1);
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                m_do[d]   = (d == 1) ? 8'hFF : 8'h00;
                m_dir[d]  = 8'h00;
                m_mask[d] = 8'h00;
                m_cap[d]  = 8'h00;
                m_rd[d]   = 32'd0;
                m_irq[d]  = 1'b0;
                m_wu[d]   = 0;
                for (int k = 0; k <= S; k++) hist[d][k] = 8'h00;
            end else begin
                sync_in = hist[d][S-1];
                prev    = hist[d][S];
                case (addr)
                    3'd0: m_rd[d] = {24'd0, sync_in};
                    3'd1: m_rd[d] = {24'd0, m_dir[d]};
                    3'd2: m_rd[d] = {24'd0, m_mask[d]};
                    3'd3: m_rd[d] = {24'd0, m_cap[d]};
                    3'd4, 3'd5: m_rd[d] = {24'd0, m_do[d]};
                    default: m_rd[d] = 32'd0;
                endcase
                m_irq[d] = (m_cap[d] & m_mask[d]) != 8'h00;
                if (d == 0) det = sync_in & ~prev;
                else        det = sync_in ^ prev;
                if (m_wu[d] != S + 1) det = 8'h00;
                clr = (cs && !wn && addr == 3'd3) ? wd[7:0] : 8'h00;
                m_cap[d] = det | (m_cap[d] & ~clr);
                if (cs && !wn) begin
                    case (addr)
                        3'd0: m_do[d]   = wd[7:0];
                        3'd1: m_dir[d]  = wd[7:0];
                        3'd2: m_mask[d] = wd[7:0];
                        3'd4: m_do[d]   = m_do[d] | wd[7:0];
                        3'd5: m_do[d]   = m_do[d] & ~wd[7:0];
                        default: ;
                    endcase
                end
                if (m_wu[d] < S + 1) m_wu[d]++;
                for (int k = S; k > 0; k--) hist[d][k] = hist[d][k-1];
                hist[d][0] = pin[d];
            end
        end
    end

    // Cycle-by-cycle compare against the model
    always @(posedge clk) begin
        #1;
        chk("rd0",   bus0.readdata, m_rd[0]);
        chk("rd1",   bus1.readdata, m_rd[1]);
        chk("irq0",  {31'd0, irq0}, {31'd0, m_irq[0]});
        chk("irq1",  {31'd0, irq1}, {31'd0, m_irq[1]});
        chk("pins0", {24'd0, pins0}, {24'd0, exp_pin(0)});
        chk("pins1", {24'd0, pins1}, {24'd0, exp_pin(1)});
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wn = 1'b0; addr = a; wd = d;
        @(negedge clk);
        cs = 1'b0; wn = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        addr = 3'd1; @(negedge clk);
        chk("t1 dir0", bus0.readdata, 32'h0);
        addr = 3'd6; @(negedge clk);
        chk("t1 addr6 d0", bus0.readdata, 32'h0);
        chk("t1 addr6 d1", bus1.readdata, 32'h0);
        chk("t1 pins0 z", {24'd0, pins0}, 32'h00);
        addr = 3'd4; @(negedge clk);
        chk("t1 out1 rst", bus1.readdata, 32'hFF);

        // Set/clear map
        wr(3'd1, 32'hFF); wr(3'd0, 32'hA5); wr(3'd4, 32'h02); wr(3'd5, 32'h80);
        addr = 3'd4; @(negedge clk);
        chk("t2 out0", bus0.readdata, 32'h27);
        chk("t2 pins0", {24'd0, pins0}, 32'h27);
        chk("t2 pins1", {24'd0, pins1}, 32'h27);

        // Open-drain readback
        wr(3'd1, 32'h01); wr(3'd0, 32'h00);
        chk("t3 pins1 low", {24'd0, pins1}, 32'hFE);
        wr(3'd0, 32'h01);
        repeat (2) @(negedge clk);
        chk("t3 rd1 early", bus1.readdata, 32'hFE);
        chk("t3 rd0 early", bus0.readdata, 32'h00);
        @(negedge clk);
        chk("t3 rd1", bus1.readdata, 32'hFF);
        chk("t3 rd0", bus0.readdata, 32'h01);

        // Edge capture and irq timing
        wr(3'd1, 32'h00); wr(3'd2, 32'h04);
        ext_oe = 8'hFF; ext_val = 8'h00;
        repeat (6) @(negedge clk);
        wr(3'd3, 32'hFF);
        addr = 3'd3; @(negedge clk);
        ext_val = 8'h04;
        repeat (3) @(negedge clk);
        chk("t4 irq0 c3", {31'd0, irq0}, 32'd0);
        @(negedge clk);
        chk("t4 irq0 c4", {31'd0, irq0}, 32'd1);
        chk("t4 cap0", bus0.readdata, 32'h04);
        wr(3'd3, 32'h04);
        chk("t4 irq0 hold", {31'd0, irq0}, 32'd1);
        @(negedge clk);
        chk("t4 irq0 clr", {31'd0, irq0}, 32'd0);

        // Edge and W1C on the same cycle
        ext_val = 8'h00;
        repeat (6) @(negedge clk);
        wr(3'd3, 32'hFF);
        ext_val = 8'h04;
        repeat (6) @(negedge clk);
        ext_val = 8'h00;
        repeat (6) @(negedge clk);
        ext_val = 8'h04;
        repeat (2) @(negedge clk);
        wr(3'd3, 32'h04);
        @(negedge clk);
        chk("t5 cap0", bus0.readdata, 32'h04);
        chk("t5 irq0", {31'd0, irq0}, 32'd1);
        chk("t5 irq1", {31'd0, irq1}, 32'd1);

        // Reset during write, pins high through warm-up
        ext_val = 8'hFF;
        reset_n = 1'b0;
        cs = 1'b1; wn = 1'b0; addr = 3'd0; wd = 32'h5A;
        @(negedge clk);
        cs = 1'b0; wn = 1'b1;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        addr = 3'd3; @(negedge clk);
        chk("t6 cap0", bus0.readdata, 32'h00);
        chk("t6 cap1", bus1.readdata, 32'h00);
        addr = 3'd4; @(negedge clk);
        chk("t6 out0", bus0.readdata, 32'h00);
        chk("t6 out1", bus1.readdata, 32'hFF);
        addr = 3'd0; @(negedge clk);
        chk("t6 data0", bus0.readdata, 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
